mem_wb_stage: RTL and testbench

- MEM/WB pipeline stage of the pipelined OTTER core.
- Captures EX/MEM results and the control bundle on each clock, and aligns and extends the raw synchronous-memory read word.
- Drives the writeback mux and register-file inputs: ALU_OUT, MEM_DOUT_2, CSR_RD, PC_4_OUT, RF_WR_SEL, regWrite, write address.
- Supports stall (hold, including raw-memory-data capture) and flush (bubble insertion).

---
 rtl/otter_pkg.sv | 25 ++
 rtl/load_align.sv | 42 ++++
 rtl/mem_wb_stage.sv | 111 +++++++++++
 tb/tb_mem_wb_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared types and encodings for the OTTER pipeline: load funct3 codes,
// writeback-select encodings and the control bundle carried from EX/MEM.
package otter_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    SEL_PC4 = 2'd0,
    SEL_CSR = 2'd1,
    SEL_MEM = 2'd2,
    SEL_ALU = 2'd3
  } wb_sel_e;

  typedef struct packed {
    wb_sel_e    rf_wr_sel;
    logic       reg_write;
    logic       mem_read;
    logic [2:0] funct3;
  } ctrl_t;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the byte/halfword/word at the given
// offset, sign- or zero-extends it, and flags misaligned or illegal loads.
module load_align
  import otter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
    data     = '0;
    err      = 1'b0;
    case (funct3)
      LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      LH: begin
        if (offset[0]) err = 1'b1;
        else           data = {{(XLEN-16){half_sel[15]}}, half_sel};
      end
      LHU: begin
        if (offset[0]) err = 1'b1;
        else           data = {{(XLEN-16){1'b0}}, half_sel};
      end
      LW: begin
        if (offset != 2'b00) err = 1'b1;
        else                 data = word;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register of the OTTER core: captures EX/MEM results,
// aligns the synchronous-memory read word and drives the writeback inputs.
module mem_wb_stage
  import otter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            CLOCK,
  input  logic            RESET_N,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic            EX_VALID,
  input  logic [XLEN-1:0] EX_ALU_OUT,
  input  logic [XLEN-1:0] EX_CSR_RD,
  input  logic [XLEN-1:0] EX_PC_4,
  input  logic [RA_W-1:0] EX_RD,
  input  logic [1:0]      EX_RF_WR_SEL,
  input  logic            EX_REG_WRITE,
  input  logic            EX_MEM_READ,
  input  logic [2:0]      EX_FUNCT3,
  input  logic [XLEN-1:0] MEM_DOUT,
  output logic [XLEN-1:0] ALU_OUT,
  output logic [XLEN-1:0] CSR_RD,
  output logic [XLEN-1:0] PC_4_OUT,
  output logic [XLEN-1:0] MEM_DOUT_2,
  output logic [1:0]      RF_WR_SEL,
  output logic [RA_W-1:0] WB_RD,
  output logic            regWrite,
  output logic            LOAD_ERR,
  output logic            WB_VALID
);

  ctrl_t           ex_ctrl;
  ctrl_t           ctrl;
  logic            valid;
  logic            held;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] csr_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] hold_word;
  logic [RA_W-1:0] rd_q;
  logic [XLEN-1:0] word_src;
  logic [XLEN-1:0] align_data;
  logic            align_err;

  always_comb begin
    ex_ctrl           = '0;
    ex_ctrl.rf_wr_sel = wb_sel_e'(EX_RF_WR_SEL);
    ex_ctrl.reg_write = EX_REG_WRITE;
    ex_ctrl.mem_read  = EX_MEM_READ;
    ex_ctrl.funct3    = EX_FUNCT3;
  end

  // The memory word is only on MEM_DOUT for one cycle; a stalled load keeps
  // its own copy so the aligned result stays stable until the stall ends.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid     <= 1'b0;
      held      <= 1'b0;
      ctrl      <= '0;
      alu_q     <= '0;
      csr_q     <= '0;
      pc4_q     <= '0;
      rd_q      <= '0;
      hold_word <= '0;
    end else if (FLUSH) begin
      valid <= 1'b0;
      held  <= 1'b0;
      ctrl  <= '0;
      alu_q <= EX_ALU_OUT;
      csr_q <= EX_CSR_RD;
      pc4_q <= EX_PC_4;
      rd_q  <= EX_RD;
    end else if (STALL) begin
      if (!held && valid && ctrl.mem_read) begin
        hold_word <= MEM_DOUT;
        held      <= 1'b1;
      end
    end else begin
      valid <= EX_VALID;
      held  <= 1'b0;
      ctrl  <= ex_ctrl;
      alu_q <= EX_ALU_OUT;
      csr_q <= EX_CSR_RD;
      pc4_q <= EX_PC_4;
      rd_q  <= EX_RD;
    end
  end

  assign word_src = held ? hold_word : MEM_DOUT;

  load_align #(.XLEN(XLEN)) u_align (
    .word   (word_src),
    .offset (alu_q[1:0]),
    .funct3 (ctrl.funct3),
    .data   (align_data),
    .err    (align_err)
  );

  assign ALU_OUT    = alu_q;
  assign CSR_RD     = csr_q;
  assign PC_4_OUT   = pc4_q;
  assign RF_WR_SEL  = ctrl.rf_wr_sel;
  assign WB_RD      = rd_q;
  assign WB_VALID   = valid;
  assign LOAD_ERR   = valid & ctrl.mem_read & align_err;
  assign MEM_DOUT_2 = ctrl.mem_read ? align_data : '0;
  assign regWrite   = valid & ctrl.reg_write & (rd_q != '0) & ~LOAD_ERR;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: the driver pushes hand-computed expected
// writeback outputs; a monitor pops and compares them on each falling edge.
module tb_mem_wb_stage;
  import otter_pkg::*;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic        EX_VALID = 1'b0;
  logic [31:0] EX_ALU_OUT = '0;
  logic [31:0] EX_CSR_RD = '0;
  logic [31:0] EX_PC_4 = '0;
  logic [4:0]  EX_RD = '0;
  logic [1:0]  EX_RF_WR_SEL = '0;
  logic        EX_REG_WRITE = 1'b0;
  logic        EX_MEM_READ = 1'b0;
  logic [2:0]  EX_FUNCT3 = '0;
  logic [31:0] MEM_DOUT = '0;
  logic [31:0] ALU_OUT, CSR_RD, PC_4_OUT, MEM_DOUT_2;
  logic [1:0]  RF_WR_SEL;
  logic [4:0]  WB_RD;
  logic        regWrite, LOAD_ERR, WB_VALID;

  mem_wb_stage #(.XLEN(32), .RA_W(5)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .STALL(STALL), .FLUSH(FLUSH),
    .EX_VALID(EX_VALID), .EX_ALU_OUT(EX_ALU_OUT), .EX_CSR_RD(EX_CSR_RD),
    .EX_PC_4(EX_PC_4), .EX_RD(EX_RD), .EX_RF_WR_SEL(EX_RF_WR_SEL),
    .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ), .EX_FUNCT3(EX_FUNCT3),
    .MEM_DOUT(MEM_DOUT), .ALU_OUT(ALU_OUT), .CSR_RD(CSR_RD), .PC_4_OUT(PC_4_OUT),
    .MEM_DOUT_2(MEM_DOUT_2), .RF_WR_SEL(RF_WR_SEL), .WB_RD(WB_RD),
    .regWrite(regWrite), .LOAD_ERR(LOAD_ERR), .WB_VALID(WB_VALID)
  );

  // clock / watchdog
  always #5 CLOCK = ~CLOCK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        err;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] dout2;
    logic [31:0] alu;
    logic [31:0] csr;
    logic [31:0] pc4;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  exp_t             cur;
  int               checks = 0;
  int               errors = 0;
  event             sample_now;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic [1:0] sel, input logic rw, input logic mr,
                       input logic [2:0] f3);
    EX_VALID     = v;
    EX_ALU_OUT   = alu;
    EX_CSR_RD    = ~alu;
    EX_PC_4      = alu + 32'h1000;
    EX_RD        = rd;
    EX_RF_WR_SEL = sel;
    EX_REG_WRITE = rw;
    EX_MEM_READ  = mr;
    EX_FUNCT3    = f3;
  endtask

  task automatic expect_out(input logic v, input logic rw, input logic err,
                            input logic [4:0] rd, input logic [1:0] sel,
                            input logic [31:0] dout2, input logic [31:0] alu,
                            input logic [31:0] csr, input logic [31:0] pc4);
    exp_t e;
    e = '{v: v, rw: rw, err: err, rd: rd, sel: sel, dout2: dout2, alu: alu, csr: csr, pc4: pc4};
    exp_q.push_back(EXP_W'(e));
  endtask

  // expected outputs for an instruction captured with drive(): csr/pc4 follow from alu
  task automatic expect_instr(input logic v, input logic rw, input logic err,
                              input logic [4:0] rd, input logic [1:0] sel,
                              input logic [31:0] dout2, input logic [31:0] alu);
    expect_out(v, rw, err, rd, sel, dout2, alu, ~alu, alu + 32'h1000);
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge CLOCK or sample_now);
      if (exp_q.size() > 0) begin
        cur = exp_t'(exp_q.pop_front());
        check("WB_VALID",   32'(WB_VALID),  32'(cur.v));
        check("regWrite",   32'(regWrite),  32'(cur.rw));
        check("LOAD_ERR",   32'(LOAD_ERR),  32'(cur.err));
        check("WB_RD",      32'(WB_RD),     32'(cur.rd));
        check("RF_WR_SEL",  32'(RF_WR_SEL), 32'(cur.sel));
        check("MEM_DOUT_2", MEM_DOUT_2,     cur.dout2);
        check("ALU_OUT",    ALU_OUT,        cur.alu);
        check("CSR_RD",     CSR_RD,         cur.csr);
        check("PC_4_OUT",   PC_4_OUT,       cur.pc4);
      end
    end
  end

  initial begin
    #1;
    expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;

    // sign-extended byte at offset 3
    drive(1, 32'h103, 5, SEL_MEM, 1, 1, LB); tick(); MEM_DOUT = 32'h80FF_1234;
    expect_instr(1, 1, 0, 5, SEL_MEM, 32'hFFFF_FF80, 32'h103);
    drive(1, 32'h102, 6, SEL_MEM, 1, 1, LHU); tick(); MEM_DOUT = 32'h8001_0000;
    expect_instr(1, 1, 0, 6, SEL_MEM, 32'h0000_8001, 32'h102);
    drive(1, 32'h101, 7, SEL_MEM, 1, 1, LH); tick(); MEM_DOUT = 32'h1234_5678;
    expect_instr(1, 0, 1, 7, SEL_MEM, 32'h0, 32'h101);
    drive(1, 32'h100, 8, SEL_MEM, 1, 1, LH); tick(); MEM_DOUT = 32'h1234_8001;
    expect_instr(1, 1, 0, 8, SEL_MEM, 32'hFFFF_8001, 32'h100);
    drive(1, 32'h101, 9, SEL_MEM, 1, 1, LBU); tick(); MEM_DOUT = 32'h0000_F000;
    expect_instr(1, 1, 0, 9, SEL_MEM, 32'h0000_00F0, 32'h101);
    drive(1, 32'h102, 10, SEL_MEM, 1, 1, LW); tick(); MEM_DOUT = 32'hAAAA_AAAA;
    expect_instr(1, 0, 1, 10, SEL_MEM, 32'h0, 32'h102);
    drive(1, 32'h100, 11, SEL_MEM, 1, 1, 3'b011); tick(); MEM_DOUT = 32'h5555_5555;
    expect_instr(1, 0, 1, 11, SEL_MEM, 32'h0, 32'h100);

    // ALU results: x0 is never written, invalid slots never write
    drive(1, 32'h55, 0, SEL_ALU, 1, 0, 3'b000); tick();
    expect_instr(1, 0, 0, 0, SEL_ALU, 32'h0, 32'h55);
    drive(1, 32'hABCD, 3, SEL_ALU, 1, 0, 3'b000); tick();
    expect_instr(1, 1, 0, 3, SEL_ALU, 32'h0, 32'hABCD);
    drive(0, 32'h66, 12, SEL_ALU, 1, 0, 3'b000); tick();
    expect_instr(0, 0, 0, 12, SEL_ALU, 32'h0, 32'h66);

    // LW held across a three-cycle stall while MEM_DOUT goes away
    drive(1, 32'h200, 13, SEL_MEM, 1, 1, LW); tick(); MEM_DOUT = 32'hDEAD_BEEF;
    expect_instr(1, 1, 0, 13, SEL_MEM, 32'hDEAD_BEEF, 32'h200);
    STALL = 1'b1;
    drive(1, 32'h999, 14, SEL_ALU, 1, 0, 3'b000);
    tick(); MEM_DOUT = 32'h0;
    expect_instr(1, 1, 0, 13, SEL_MEM, 32'hDEAD_BEEF, 32'h200);
    tick();
    expect_instr(1, 1, 0, 13, SEL_MEM, 32'hDEAD_BEEF, 32'h200);
    tick();
    expect_instr(1, 1, 0, 13, SEL_MEM, 32'hDEAD_BEEF, 32'h200);

    // FLUSH wins over STALL and inserts a bubble
    FLUSH = 1'b1;
    drive(1, 32'h77, 7, SEL_ALU, 1, 0, 3'b000); tick();
    expect_instr(0, 0, 0, 7, SEL_PC4, 32'h0, 32'h77);
    FLUSH = 1'b0;
    STALL = 1'b0;

    // reset asserted mid-cycle during a stalled load
    drive(1, 32'h300, 15, SEL_MEM, 1, 1, LW); tick(); MEM_DOUT = 32'h1122_3344;
    expect_instr(1, 1, 0, 15, SEL_MEM, 32'h1122_3344, 32'h300);
    STALL = 1'b1;
    tick();
    expect_instr(1, 1, 0, 15, SEL_MEM, 32'h1122_3344, 32'h300);
    #6;
    RESET_N = 1'b0;
    #1;
    expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0);
    -> sample_now;
    @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    STALL = 1'b0;
    drive(1, 32'h400, 16, SEL_MEM, 1, 1, LW); tick(); MEM_DOUT = 32'hCAFE_F00D;
    expect_instr(1, 1, 0, 16, SEL_MEM, 32'hCAFE_F00D, 32'h400);
    drive(0, 32'h0, 0, SEL_PC4, 0, 0, 3'b000);

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
